// File: rtl/palette_controller.sv
// Colour palette with CPU-side shadow table, pixel-side active table and a
// vblank-triggered shadow-to-active commit engine.
module palette_controller #(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CHAN_W  = 2,
  parameter int unsigned NUM_RD  = 2
) (
  input  logic                         video_clk,
  input  logic                         reset_n,
  input  logic [1:0]                   reg_sel,
  input  logic                         reg_wr,
  input  logic                         reg_rd,
  input  logic [7:0]                   reg_wdata,
  output logic [7:0]                   reg_rdata,
  input  logic                         vblank,
  input  logic [NUM_RD*INDEX_W-1:0]    rd_addr,
  output logic [NUM_RD*3*CHAN_W-1:0]   rd_data,
  output logic                         commit_busy
);

  localparam int unsigned ENTRIES = 1 << INDEX_W;
  localparam int unsigned ENTRY_W = 3 * CHAN_W;
  localparam logic [1:0]  SEL_INDEX = 2'd0;
  localparam logic [1:0]  SEL_DATA  = 2'd1;
  localparam logic [1:0]  SEL_CTRL  = 2'd2;

  typedef enum logic {IDLE, COPY} state_t;
  typedef enum logic [1:0] {PH_R, PH_G, PH_B} phase_t;

  logic [ENTRY_W-1:0] shadow [ENTRIES];
  logic [ENTRY_W-1:0] active [ENTRIES];
  logic [INDEX_W-1:0] ptr;
  logic [INDEX_W-1:0] copy_idx;
  logic [CHAN_W-1:0]  stage_r;
  logic [CHAN_W-1:0]  stage_g;
  logic [CHAN_W-1:0]  rd_comp_c;
  logic [ENTRY_W-1:0] new_entry_c;
  phase_t             ph;
  state_t             state;
  logic               mode;
  logic               pending;
  logic               vblank_q;
  logic               unused_wdata_c;

  // Grey ramp: each component takes the top CHAN_W bits of the index.
  function automatic logic [ENTRY_W-1:0] ramp_entry(input int unsigned i);
    logic [CHAN_W-1:0] c;
    int sh;
    sh = int'(INDEX_W) - int'(CHAN_W);
    if (sh >= 0) c = CHAN_W'(i >> sh);
    else         c = CHAN_W'(i << (-sh));
    return {c, c, c};
  endfunction

  assign unused_wdata_c = ^reg_wdata;
  assign new_entry_c    = {stage_r, stage_g, reg_wdata[CHAN_W-1:0]};

  always_comb begin
    rd_comp_c = '0;
    case (ph)
      PH_R:    rd_comp_c = shadow[ptr][ENTRY_W-1 -: CHAN_W];
      PH_G:    rd_comp_c = shadow[ptr][2*CHAN_W-1 -: CHAN_W];
      default: rd_comp_c = shadow[ptr][CHAN_W-1:0];
    endcase
  end

  always_ff @(posedge video_clk) begin
    if (!reset_n) begin
      ptr         <= '0;
      ph          <= PH_R;
      mode        <= 1'b0;
      pending     <= 1'b0;
      state       <= IDLE;
      commit_busy <= 1'b0;
      reg_rdata   <= '0;
      rd_data     <= '0;
      vblank_q    <= 1'b0;
      copy_idx    <= '0;
      stage_r     <= '0;
      stage_g     <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        shadow[i] <= ramp_entry(i);
        active[i] <= ramp_entry(i);
      end
    end else begin
      vblank_q <= vblank;

      for (int unsigned p = 0; p < NUM_RD; p++)
        rd_data[p*ENTRY_W +: ENTRY_W] <= active[rd_addr[p*INDEX_W +: INDEX_W]];

      // Commit engine: one entry per cycle from index 0 upward.
      case (state)
        IDLE: begin
          if (vblank && !vblank_q && pending) begin
            state       <= COPY;
            commit_busy <= 1'b1;
            pending     <= 1'b0;
            copy_idx    <= '0;
          end
        end
        default: begin
          active[copy_idx] <= shadow[copy_idx];
          copy_idx         <= copy_idx + INDEX_W'(1);
          if (copy_idx == INDEX_W'(ENTRIES - 1)) begin
            state       <= IDLE;
            commit_busy <= 1'b0;
          end
        end
      endcase

      // Register port; a write wins over a simultaneous read.
      if (reg_wr) begin
        case (reg_sel)
          SEL_INDEX: begin
            ptr     <= reg_wdata[INDEX_W-1:0];
            ph      <= PH_R;
            stage_r <= '0;
            stage_g <= '0;
          end
          SEL_DATA: begin
            case (ph)
              PH_R: begin
                stage_r <= reg_wdata[CHAN_W-1:0];
                ph      <= PH_G;
              end
              PH_G: begin
                stage_g <= reg_wdata[CHAN_W-1:0];
                ph      <= PH_B;
              end
              default: begin
                shadow[ptr] <= new_entry_c;
                if (!mode) active[ptr] <= new_entry_c;
                if (state == COPY && ptr <= copy_idx) pending <= 1'b1;
                ph  <= PH_R;
                ptr <= ptr + INDEX_W'(1);
              end
            endcase
          end
          SEL_CTRL: begin
            mode <= reg_wdata[0];
            if (reg_wdata[1]) pending <= 1'b1;
          end
          default: ;
        endcase
      end else if (reg_rd) begin
        case (reg_sel)
          SEL_INDEX: reg_rdata <= 8'(ptr);
          SEL_DATA: begin
            reg_rdata <= 8'(rd_comp_c);
            stage_r   <= '0;
            stage_g   <= '0;
            case (ph)
              PH_R:    ph <= PH_G;
              PH_G:    ph <= PH_B;
              default: begin
                ph  <= PH_R;
                ptr <= ptr + INDEX_W'(1);
              end
            endcase
          end
          SEL_CTRL: reg_rdata <= {6'b0, pending, mode};
          default:  reg_rdata <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_palette_controller.sv
// Directed bench for palette_controller: stimulus queues expected register
// reads and pixel lookups; a negedge monitor pops and compares them.
module tb_palette_controller;

  localparam int unsigned IW = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned NR = 2;

  logic             video_clk = 1'b0;
  logic             reset_n   = 1'b0;
  logic [1:0]       reg_sel   = '0;
  logic             reg_wr    = 1'b0;
  logic             reg_rd    = 1'b0;
  logic [7:0]       reg_wdata = '0;
  logic [7:0]       reg_rdata;
  logic             vblank    = 1'b0;
  logic [NR*IW-1:0] rd_addr   = '0;
  logic [NR*3*CW-1:0] rd_data;
  logic             commit_busy;

  int tests = 0;
  int fails = 0;

  logic [7:0]  rq[$];
  string       rn[$];
  logic [11:0] pq[$];
  string       pn[$];
  logic rd_issued = 1'b0, pix_issued = 1'b0, rd_d = 1'b0, pix_d = 1'b0;

  always #5 video_clk = ~video_clk;

  palette_controller #(.INDEX_W(IW), .CHAN_W(CW), .NUM_RD(NR)) dut (
    .video_clk  (video_clk),
    .reset_n    (reset_n),
    .reg_sel    (reg_sel),
    .reg_wr     (reg_wr),
    .reg_rd     (reg_rd),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .vblank     (vblank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .commit_busy(commit_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responses are due one cycle after the strobe is sampled.
  always @(posedge video_clk) begin
    rd_d  <= rd_issued;
    pix_d <= pix_issued;
  end

  always @(negedge video_clk) begin : monitor
    logic [7:0]  re;
    logic [11:0] pe;
    string       nm;
    if (rd_d) begin
      if (rq.size() == 0) check("reg_unexpected", 1, 0);
      else begin
        re = rq.pop_front();
        nm = rn.pop_front();
        check(nm, 32'(reg_rdata), 32'(re));
      end
    end
    if (pix_d) begin
      if (pq.size() == 0) check("pix_unexpected", 1, 0);
      else begin
        pe = pq.pop_front();
        nm = pn.pop_front();
        check(nm, 32'(rd_data), 32'(pe));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge video_clk);
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [7:0] d);
    reg_sel = sel; reg_wdata = d; reg_wr = 1'b1;
    @(negedge video_clk);
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] sel, input logic [7:0] exp, input string name);
    reg_sel = sel; reg_rd = 1'b1; rd_issued = 1'b1;
    rq.push_back(exp); rn.push_back(name);
    @(negedge video_clk);
    reg_rd = 1'b0; rd_issued = 1'b0;
  endtask

  task automatic pix(input logic [3:0] a0, input logic [3:0] a1,
                     input logic [5:0] e0, input logic [5:0] e1, input string name);
    rd_addr = {a1, a0}; pix_issued = 1'b1;
    pq.push_back({e1, e0}); pn.push_back(name);
    @(negedge video_clk);
    pix_issued = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input string name);
    int n = 0;
    while (commit_busy !== level && n < 50) begin
      @(negedge video_clk);
      n++;
    end
    check(name, 32'(commit_busy), 32'(level));
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (commit_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge video_clk);
    end
  endtask

  initial begin
    int nb;
    idle(3);
    check("rst_rdata", 32'(reg_rdata), 0);
    check("rst_busy", 32'(commit_busy), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    reset_n = 1'b1;
    idle(1);

    // Reset state and ramp contents.
    reg_read(2'd2, 8'h00, "rst_ctrl");
    reg_read(2'd0, 8'h00, "rst_index");
    pix(4'hF, 4'h4, 6'b111111, 6'b010101, "ramp_f_4");
    pix(4'h3, 4'h0, 6'b000000, 6'b000000, "ramp_3_0");

    // Immediate write with upper data bits ignored; both ports on one index.
    reg_write(2'd0, 8'h03);
    reg_write(2'd1, 8'hFD);
    reg_write(2'd1, 8'h02);
    reg_write(2'd1, 8'h03);
    pix(4'h3, 4'h3, 6'b011011, 6'b011011, "imm_entry3");
    reg_read(2'd0, 8'h04, "imm_index");
    reg_write(2'd0, 8'h03);
    reg_read(2'd1, 8'h01, "data_rd_r");
    reg_read(2'd1, 8'h02, "data_rd_g");
    reg_read(2'd1, 8'h03, "data_rd_b");
    reg_read(2'd0, 8'h04, "data_rd_index");

    // Pointer wrap from 15 to 0.
    reg_write(2'd0, 8'h0F);
    reg_write(2'd1, 8'h03);
    reg_write(2'd1, 8'h00);
    reg_write(2'd1, 8'h01);
    reg_write(2'd1, 8'h02);
    reg_write(2'd1, 8'h02);
    reg_write(2'd1, 8'h02);
    reg_read(2'd0, 8'h01, "wrap_index");
    pix(4'hF, 4'h0, 6'b110001, 6'b101010, "wrap_entries");

    // Reserved select and write-over-read priority.
    reg_write(2'd3, 8'hFF);
    reg_read(2'd3, 8'h00, "rsvd_read");
    reg_read(2'd2, 8'h00, "rsvd_ctrl");
    reg_read(2'd0, 8'h01, "rsvd_index");
    reg_sel = 2'd0; reg_wdata = 8'h07; reg_wr = 1'b1; reg_rd = 1'b1; rd_issued = 1'b1;
    rq.push_back(8'h01); rn.push_back("wr_rd_hold");
    @(negedge video_clk);
    reg_wr = 1'b0; reg_rd = 1'b0; rd_issued = 1'b0;
    reg_read(2'd0, 8'h07, "wr_rd_index");

    // Deferred mode: active only changes through the commit.
    reg_write(2'd2, 8'h01);
    reg_read(2'd2, 8'h01, "def_ctrl");
    reg_write(2'd0, 8'h05);
    reg_write(2'd1, 8'h03);
    reg_write(2'd1, 8'h03);
    reg_write(2'd1, 8'h03);
    pix(4'h5, 4'h5, 6'b010101, 6'b010101, "def_no_change");
    reg_write(2'd0, 8'h05);
    reg_read(2'd1, 8'h03, "def_shadow");
    reg_write(2'd2, 8'h03);
    reg_read(2'd2, 8'h03, "def_pending");
    idle(3);
    check("def_busy_idle", 32'(commit_busy), 0);
    pix(4'h5, 4'h4, 6'b010101, 6'b010101, "def_still_old");
    vblank = 1'b1;
    wait_busy(1'b1, "copy1_start");
    count_busy(nb);
    check("copy1_cycles", 32'(nb), 16);
    reg_read(2'd2, 8'h01, "copy1_ctrl");
    pix(4'h5, 4'h4, 6'b111111, 6'b010101, "copy1_entry5");

    // Write an already-copied entry mid-commit: pending re-arms.
    vblank = 1'b0;
    idle(2);
    reg_write(2'd2, 8'h03);
    vblank = 1'b1;
    wait_busy(1'b1, "copy2_start");
    idle(2);
    reg_write(2'd0, 8'h00);
    reg_write(2'd1, 8'h01);
    reg_write(2'd1, 8'h01);
    reg_write(2'd1, 8'h01);
    reg_read(2'd2, 8'h03, "copy2_repend");
    wait_busy(1'b0, "copy2_end");
    pix(4'h0, 4'h5, 6'b101010, 6'b111111, "copy2_entry0_old");
    vblank = 1'b0;
    idle(2);
    vblank = 1'b1;
    wait_busy(1'b1, "copy3_start");
    wait_busy(1'b0, "copy3_end");
    pix(4'h0, 4'h5, 6'b010101, 6'b111111, "copy3_entry0_new");
    reg_read(2'd2, 8'h01, "copy3_ctrl");

    // Reset in the middle of a commit.
    reg_write(2'd2, 8'h03);
    vblank = 1'b0;
    idle(2);
    vblank = 1'b1;
    wait_busy(1'b1, "copy4_start");
    idle(3);
    reset_n = 1'b0;
    @(negedge video_clk);
    check("mid_rst_busy", 32'(commit_busy), 0);
    check("mid_rst_rdata", 32'(reg_rdata), 0);
    check("mid_rst_rd_data", 32'(rd_data), 0);
    reset_n = 1'b1;
    vblank = 1'b0;
    pix(4'h5, 4'h0, 6'b010101, 6'b000000, "post_rst_5_0");
    pix(4'hF, 4'h3, 6'b111111, 6'b000000, "post_rst_f_3");
    reg_read(2'd2, 8'h00, "post_rst_ctrl");
    reg_write(2'd0, 8'h0F);
    reg_read(2'd1, 8'h03, "post_rst_shadow15");
    reg_read(2'd0, 8'h0F, "post_rst_index");

    idle(3);
    check("queues_drained", 32'(rq.size() + pq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
